btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 199 +++++++++++++++++++
 tb/tb_btn_conditioner.sv | 132 +++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Multi-channel push-button conditioner. Each channel:
//     - synchronizes its raw level through two flops,
//     - debounces it (a level change is accepted after DB_CYCLES stable cycles),
//     - emits one-cycle press / release pulses on accepted edges,
//     - optionally (REPEAT_MASK[i]) emits auto-repeat pulses while held:
//       the first one HOLD_CYCLES after the press, then every REPEAT_CYCLES.
//   Ports:
//     clk          system clock, all state on the rising edge
//     rst          synchronous active-high reset
//     btn_raw      [N_BTN] asynchronous raw levels, 1 = pressed
//     btn_level    [N_BTN] debounced level
//     btn_press    [N_BTN] one-cycle pulse on accepted 0->1
//     btn_release  [N_BTN] one-cycle pulse on accepted 1->0
//     btn_repeat   [N_BTN] one-cycle auto-repeat pulse while held
//   All outputs come straight from flops.

// One conditioner channel.
//   clk, rst   clock / synchronous active-high reset
//   raw        asynchronous raw button level
//   level      debounced level
//   press/rel  one-cycle pulses on accepted 0->1 / 1->0
//   rpt        one-cycle auto-repeat pulse (tied 0 when REPEAT_EN = 0)
module btn_chan #(
    parameter int DB_CYCLES     = 65536,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter bit REPEAT_EN     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);
    localparam int               DBW    = $clog2(DB_CYCLES);
    localparam logic [DBW-1:0]   DB_MAX = DBW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        REPEATING
    } rpt_state_e;

    logic           s1_q, s1_d;
    logic           s2_q, s2_d;
    logic [DBW-1:0] cnt_q, cnt_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           rel_q, rel_d;

    // Debounce: count consecutive cycles where the synchronized value
    // disagrees with the accepted level; any agreement restarts the count.
    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (s2_q != level_q) begin
            if (cnt_q == DB_MAX) begin
                level_d = ~level_q;
                press_d = ~level_q;
                rel_d   = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

    if (REPEAT_EN) begin : g_rpt
        localparam int             SPAN     = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                            : REPEAT_CYCLES;
        localparam int             RW       = $clog2(SPAN);
        localparam logic [RW-1:0]  HOLD_MAX = RW'(HOLD_CYCLES - 1);
        localparam logic [RW-1:0]  REP_MAX  = RW'(REPEAT_CYCLES - 1);

        rpt_state_e    state_q, state_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          rpt_q, rpt_d;

        // The counter is zero on the press edge, so it reads k at edge P+k;
        // firing when it holds HOLD_MAX puts the first pulse at P+HOLD_CYCLES.
        // Reloading to zero on every pulse keeps it below its span.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            rpt_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    rcnt_d = '0;
                    if (press_d) state_d = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (rel_d) begin
                        // release on the firing edge suppresses the pulse
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == HOLD_MAX) begin
                        rpt_d   = 1'b1;
                        rcnt_d  = '0;
                        state_d = REPEATING;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                REPEATING: begin
                    if (rel_d) begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == REP_MAX) begin
                        rpt_d  = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
                rpt_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
                rpt_q   <= rpt_d;
            end
        end

        assign rpt = rpt_q;
    end else begin : g_no_rpt
        assign rpt = 1'b0;
    end
endmodule

module btn_conditioner #(
    parameter int               N_BTN         = 4,
    parameter int               DB_CYCLES     = 65536,
    parameter int               HOLD_CYCLES   = 50000000,
    parameter int               REPEAT_CYCLES = 10000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_chan #(
            .DB_CYCLES    (DB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rel  (btn_release[i]),
            .rpt  (btn_repeat[i])
        );
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4, HOLD_CYCLES=16,
// REPEAT_CYCLES=8, REPEAT_MASK=4'b0001. Inputs are driven 1 time unit after
// a rising edge; outputs are checked 1 time unit after the next rising edge.
module tb_btn_conditioner;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

    int n_pass  = 0;
    int n_total = 0;

    btn_conditioner #(
        .N_BTN        (4),
        .DB_CYCLES    (4),
        .HOLD_CYCLES  (16),
        .REPEAT_CYCLES(8),
        .REPEAT_MASK  (4'b0001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  raw;
        logic [15:0] exp;   // {level, press, release, repeat}
    } vec_t;

    vec_t tbl [28];

    function automatic logic [15:0] ex(input logic [3:0] l, input logic [3:0] p,
                                       input logic [3:0] r, input logic [3:0] q);
        return {l, p, r, q};
    endfunction

    // Apply one cycle of inputs, clock once, compare all outputs.
    task automatic step(input logic r, input logic [3:0] raw, input logic [15:0] exp,
                        input string name);
        logic [15:0] got;
        rst     = r;
        btn_raw = raw;
        @(posedge clk);
        #1;
        got = {btn_level, btn_press, btn_release, btn_repeat};
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got lvl=%b prs=%b rel=%b rpt=%b, want lvl=%b prs=%b rel=%b rpt=%b",
                      name, got[15:12], got[11:8], got[7:4], got[3:0],
                      exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
    endtask

    initial begin
        // Rows: inputs before edge r+1, expected outputs after that edge.
        // ch0+ch1 rise together; ch1 drops after 3 cycles (never accepted).
        for (int r = 0; r < 3; r++) tbl[r] = '{4'b0011, ex(4'b0000, 4'b0000, 4'b0000, 4'b0000)};
        for (int r = 3; r < 5; r++) tbl[r] = '{4'b0001, ex(4'b0000, 4'b0000, 4'b0000, 4'b0000)};
        tbl[5] = '{4'b0001, ex(4'b0001, 4'b0001, 4'b0000, 4'b0000)};
        tbl[6] = '{4'b0001, ex(4'b0001, 4'b0000, 4'b0000, 4'b0000)};
        for (int r = 7; r < 12; r++) tbl[r] = '{4'b0000, ex(4'b0001, 4'b0000, 4'b0000, 4'b0000)};
        tbl[12] = '{4'b0000, ex(4'b0000, 4'b0000, 4'b0001, 4'b0000)};
        tbl[13] = '{4'b0000, ex(4'b0000, 4'b0000, 4'b0000, 4'b0000)};
        // all four channels at once
        for (int r = 14; r < 19; r++) tbl[r] = '{4'b1111, ex(4'b0000, 4'b0000, 4'b0000, 4'b0000)};
        tbl[19] = '{4'b1111, ex(4'b1111, 4'b1111, 4'b0000, 4'b0000)};
        tbl[20] = '{4'b1111, ex(4'b1111, 4'b0000, 4'b0000, 4'b0000)};
        for (int r = 21; r < 26; r++) tbl[r] = '{4'b0000, ex(4'b1111, 4'b0000, 4'b0000, 4'b0000)};
        tbl[26] = '{4'b0000, ex(4'b0000, 4'b0000, 4'b1111, 4'b0000)};
        tbl[27] = '{4'b0000, ex(4'b0000, 4'b0000, 4'b0000, 4'b0000)};

        // reset state
        step(1'b1, 4'b0000, 16'h0000, "reset0");
        step(1'b1, 4'b0000, 16'h0000, "reset1");

        for (int r = 0; r < 28; r++)
            step(1'b0, tbl[r].raw, tbl[r].exp, $sformatf("table[%0d]", r));

        // Long hold on ch0 (repeat enabled) and ch2 (repeat disabled).
        for (int k = 1; k <= 5; k++)
            step(1'b0, 4'b0101, 16'h0000, $sformatf("hold_pre[%0d]", k));
        step(1'b0, 4'b0101, ex(4'b0101, 4'b0101, 4'b0000, 4'b0000), "hold_press");
        for (int k = 1; k <= 40; k++)
            step(1'b0, 4'b0101,
                 ex(4'b0101, 4'b0000, 4'b0000,
                    (k == 16 || k == 24 || k == 32 || k == 40) ? 4'b0001 : 4'b0000),
                 $sformatf("hold_rpt[P+%0d]", k));
        for (int k = 41; k <= 45; k++)
            step(1'b0, 4'b0000, ex(4'b0101, 4'b0000, 4'b0000, 4'b0000),
                 $sformatf("hold_rel_wait[P+%0d]", k));
        step(1'b0, 4'b0000, ex(4'b0000, 4'b0000, 4'b0101, 4'b0000), "hold_release");
        step(1'b0, 4'b0000, 16'h0000, "hold_after");

        // Release accepted exactly on the edge a repeat would fire (P+24).
        for (int k = 1; k <= 5; k++)
            step(1'b0, 4'b0001, 16'h0000, $sformatf("race_pre[%0d]", k));
        step(1'b0, 4'b0001, ex(4'b0001, 4'b0001, 4'b0000, 4'b0000), "race_press");
        for (int k = 1; k <= 26; k++) begin
            logic [15:0] e;
            if (k < 24)       e = ex(4'b0001, 4'b0000, 4'b0000, (k == 16) ? 4'b0001 : 4'b0000);
            else if (k == 24) e = ex(4'b0000, 4'b0000, 4'b0001, 4'b0000);
            else              e = 16'h0000;
            step(1'b0, (k <= 18) ? 4'b0001 : 4'b0000, e, $sformatf("race[P+%0d]", k));
        end

        // Reset mid-debounce (ch3) with ch0 already accepted; both held through.
        for (int k = 1; k <= 5; k++)
            step(1'b0, 4'b0001, 16'h0000, $sformatf("rst_pre[%0d]", k));
        step(1'b0, 4'b0001, ex(4'b0001, 4'b0001, 4'b0000, 4'b0000), "rst_press0");
        for (int k = 1; k <= 3; k++)
            step(1'b0, 4'b1001, ex(4'b0001, 4'b0000, 4'b0000, 4'b0000),
                 $sformatf("rst_mid[%0d]", k));
        step(1'b1, 4'b1001, 16'h0000, "rst_assert");
        for (int k = 1; k <= 7; k++) begin
            logic [15:0] e;
            if (k < 6)       e = 16'h0000;
            else if (k == 6) e = ex(4'b1001, 4'b1001, 4'b0000, 4'b0000);
            else             e = ex(4'b1001, 4'b0000, 4'b0000, 4'b0000);
            step(1'b0, 4'b1001, e, $sformatf("rst_repress[%0d]", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
